// File: rtl/lmi_ifetch_queue.sv
// Instruction-fetch front end: issues in-order reads to the I-RAM wrapper, buffers
// returned words with their PCs in a small FIFO, and flushes on redirect.
module lmi_ifetch_queue #(
   parameter int          DEPTH        = 4,
   parameter int          MAX_OUT      = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
   input  logic        CLK,
   input  logic        RESET_D1_R_N,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_ADDR,
   input  logic        HALT,
   output logic [31:0] NEXTADDR,
   output logic        RDOP_N,
   output logic        IS_VAL,
   input  logic        IW_ACK,
   input  logic [31:0] IW_DATAUPO,
   input  logic        IW_MISS_R,
   output logic [31:0] IF_INSTR,
   output logic [31:0] IF_PC,
   output logic        IF_VALID,
   input  logic        DEC_READY,
   output logic [4:0]  IF_LEVEL,
   output logic        IF_PROTERR
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [31:0]   fetch_pc, resp_pc;
   logic [1:0]    outstanding, discard;
   logic [4:0]    level;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          run, proterr;
   logic          issue, ack_ok, push, pop;
   logic [5:0]    credit;
   logic [31:0]   redir_pc;

   // Miss status and the byte offset of the redirect target carry no control meaning.
   logic unused_ok;
   assign unused_ok = ^{IW_MISS_R, REDIRECT_ADDR[1:0]};

   assign redir_pc = {REDIRECT_ADDR[31:2], 2'b00};

   // A request only goes out when a FIFO slot is already reserved for its response,
   // so acks never need backpressure.
   always_comb begin
      credit = 6'(level) + 6'(outstanding);
      issue  = run & ~HALT & ~REDIRECT & (outstanding < 2'(MAX_OUT)) & (credit < 6'(DEPTH));
      ack_ok = IW_ACK & (outstanding != 2'd0);
      push   = ack_ok & (discard == 2'd0) & ~REDIRECT;
      pop    = (level != 5'd0) & DEC_READY & ~REDIRECT;
   end

   always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
      if (!RESET_D1_R_N) begin
         run         <= 1'b0;
         proterr     <= 1'b0;
         fetch_pc    <= RESET_VECTOR;
         resp_pc     <= RESET_VECTOR;
         outstanding <= 2'd0;
         discard     <= 2'd0;
         level       <= 5'd0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         run <= 1'b1;
         if (IW_ACK && outstanding == 2'd0) proterr <= 1'b1;
         outstanding <= outstanding + 2'(issue) - 2'(ack_ok);
         if (REDIRECT) begin
            // Everything still in flight belongs to the old path; an ack landing
            // in this very cycle is already retired from the count.
            fetch_pc <= redir_pc;
            resp_pc  <= redir_pc;
            discard  <= outstanding - 2'(ack_ok);
            level    <= 5'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (ack_ok && discard != 2'd0) discard <= discard - 2'd1;
            if (push) begin
               mem[wr_ptr] <= '{instr: IW_DATAUPO, pc: resp_pc};
               wr_ptr      <= wr_ptr + PW'(1);
               resp_pc     <= resp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + 5'(push) - 5'(pop);
         end
      end
   end

   assign NEXTADDR   = fetch_pc;
   assign RDOP_N     = ~issue;
   assign IS_VAL     = issue;
   assign IF_INSTR   = mem[rd_ptr].instr;
   assign IF_PC      = mem[rd_ptr].pc;
   assign IF_VALID   = (level != 5'd0);
   assign IF_LEVEL   = level;
   assign IF_PROTERR = proterr;

endmodule

// File: tb/tb_lmi_ifetch_queue.sv
// Bench for lmi_ifetch_queue: in-order bus responder, request-address model and a
// decode-side scoreboard, driven by directed scenarios.
module tb_lmi_ifetch_queue;

   localparam int MAX_OUT = 2;

   logic        CLK, RESET_D1_R_N, REDIRECT, HALT, IW_ACK, IW_MISS_R, DEC_READY;
   logic [31:0] REDIRECT_ADDR, NEXTADDR, IW_DATAUPO, IF_INSTR, IF_PC;
   logic        RDOP_N, IS_VAL, IF_VALID, IF_PROTERR;
   logic [4:0]  IF_LEVEL;

   lmi_ifetch_queue #(.DEPTH(4), .MAX_OUT(MAX_OUT), .RESET_VECTOR(32'h8000_0000)) dut (
      .CLK(CLK), .RESET_D1_R_N(RESET_D1_R_N), .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
      .HALT(HALT), .NEXTADDR(NEXTADDR), .RDOP_N(RDOP_N), .IS_VAL(IS_VAL), .IW_ACK(IW_ACK),
      .IW_DATAUPO(IW_DATAUPO), .IW_MISS_R(IW_MISS_R), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
      .IF_VALID(IF_VALID), .DEC_READY(DEC_READY), .IF_LEVEL(IF_LEVEL), .IF_PROTERR(IF_PROTERR)
   );

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

   pend_t       pend[$];
   exp_t        exp_q[$];
   int          nvec = 0, nmis = 0;
   int          req_cnt = 0, dec_cnt = 0, cnt = 0, lat = 1;
   bit          force_ack = 0, saw_zero = 0;
   logic [31:0] exp_req_pc = 32'h8000_0000;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] dfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Responder: acks pending reads in order at their due cycle; force_ack acks now
   // (or fakes an ack when nothing is pending). Requests are captured mid-cycle.
   initial begin
      pend_t pe;
      IW_ACK = 1'b0; IW_DATAUPO = '0; IW_MISS_R = 1'b0;
      forever begin
         @(negedge CLK); cnt++;
         #1;
         IW_ACK = 1'b0; IW_DATAUPO = '0;
         if (force_ack || (pend.size() > 0 && pend[0].due <= cnt)) begin
            IW_ACK = 1'b1;
            if (pend.size() > 0) begin
               pe = pend.pop_front();
               IW_DATAUPO = dfn(pe.addr);
            end else IW_DATAUPO = 32'hDEAD_BEEF;
         end
         IW_MISS_R = (pend.size() > 0) && !IW_ACK;
         #1;
         if (IS_VAL) begin
            chk("req_addr", NEXTADDR, exp_req_pc);
            chk("req_rdop_n", 32'(RDOP_N), 32'd0);
            exp_q.push_back('{pc: exp_req_pc, data: dfn(exp_req_pc)});
            pend.push_back('{addr: NEXTADDR, due: cnt + lat});
            if (NEXTADDR == 32'h0) saw_zero = 1'b1;
            exp_req_pc += 32'd4;
            req_cnt++;
            chk("max_outstanding", 32'(pend.size() <= MAX_OUT), 32'd1);
         end
      end
   end

   // Decode-side monitor: every accepted head entry must match the scoreboard front.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK); #3;
         if (IF_VALID && DEC_READY && !REDIRECT) begin
            if (exp_q.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL dec_unexpected: got pc %h instr %h, expected no entry", IF_PC, IF_INSTR);
            end else begin
               e = exp_q.pop_front();
               chk("if_pc", IF_PC, e.pc);
               chk("if_instr", IF_INSTR, e.data);
               dec_cnt++;
            end
         end
      end
   end

   // Enter and leave at negedge time 0.
   task automatic issue_n(input int n, input string nm);
      int  s;
      bit  done;
      s = req_cnt; done = 0; HALT = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         #4; done = (req_cnt - s >= n);
         @(negedge CLK);
      end
      HALT = 1'b1;
      chk(nm, 32'(req_cnt - s), 32'(n));
   endtask

   task automatic drain(input string nm);
      bit ok;
      HALT = 1'b1; DEC_READY = 1'b1; ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         #4; ok = (pend.size() == 0) && !IW_ACK && !IF_VALID;
         @(negedge CLK);
      end
      chk({nm, "_drained"}, 32'(ok), 32'd1);
      chk({nm, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "_level"}, 32'(IF_LEVEL), 32'd0);
   endtask

   task automatic redirect_to(input logic [31:0] a, input logic [31:0] aligned);
      REDIRECT = 1'b1; REDIRECT_ADDR = a;
      #4; exp_q.delete(); exp_req_pc = aligned;
      @(negedge CLK);
      REDIRECT = 1'b0;
   endtask

   initial begin
      int s, d0;
      RESET_D1_R_N = 1'b0; REDIRECT = 1'b0; REDIRECT_ADDR = '0; HALT = 1'b0; DEC_READY = 1'b0;
      repeat (2) @(negedge CLK);
      #4;
      chk("rst_rdop_n", 32'(RDOP_N), 32'd1);
      chk("rst_is_val", 32'(IS_VAL), 32'd0);
      chk("rst_nextaddr", NEXTADDR, 32'h8000_0000);
      chk("rst_if_valid", 32'(IF_VALID), 32'd0);
      chk("rst_if_level", 32'(IF_LEVEL), 32'd0);
      chk("rst_if_instr", IF_INSTR, 32'd0);
      chk("rst_if_pc", IF_PC, 32'd0);
      chk("rst_proterr", 32'(IF_PROTERR), 32'd0);

      // Streaming fetch from the reset vector, ack one cycle after each request.
      @(negedge CLK);
      RESET_D1_R_N = 1'b1; DEC_READY = 1'b1; lat = 1;
      repeat (12) @(negedge CLK);
      #4; chk("t1_throughput", 32'(dec_cnt >= 8), 32'd1);
      @(negedge CLK);
      drain("t1");

      // Decode stalled: credits cap issue at the FIFO depth; one pop frees one slot.
      DEC_READY = 1'b0; lat = 1; s = req_cnt; HALT = 1'b0;
      repeat (10) @(negedge CLK);
      #4;
      chk("t2_reqs_full", 32'(req_cnt - s), 32'd4);
      chk("t2_level_full", 32'(IF_LEVEL), 32'd4);
      chk("t2_rdop_idle", 32'(RDOP_N), 32'd1);
      @(negedge CLK); DEC_READY = 1'b1;
      @(negedge CLK); DEC_READY = 1'b0;
      #4;
      chk("t2_reissue", 32'(IS_VAL), 32'd1);
      chk("t2_reqs_after_pop", 32'(req_cnt - s), 32'd5);
      chk("t2_level_after_pop", 32'(IF_LEVEL), 32'd3);
      repeat (3) @(negedge CLK);
      #4;
      chk("t2_level_refill", 32'(IF_LEVEL), 32'd4);
      chk("t2_reqs_final", 32'(req_cnt - s), 32'd5);
      @(negedge CLK);
      drain("t2");

      // Redirect with two entries buffered and two reads outstanding.
      DEC_READY = 1'b0; lat = 1;
      issue_n(2, "t3_fill_reqs");
      repeat (3) @(negedge CLK);
      #4; chk("t3_level_pre", 32'(IF_LEVEL), 32'd2);
      @(negedge CLK);
      lat = 10;
      issue_n(2, "t3_miss_reqs");
      d0 = dec_cnt;
      redirect_to(32'h0000_1003, 32'h0000_1000);
      DEC_READY = 1'b1; HALT = 1'b0; lat = 1;
      #4;
      chk("t3_flush_level", 32'(IF_LEVEL), 32'd0);
      chk("t3_flush_valid", 32'(IF_VALID), 32'd0);
      @(negedge CLK);
      repeat (14) @(negedge CLK);
      drain("t3");
      chk("t3_new_path_decoded", 32'(dec_cnt > d0), 32'd1);

      // Redirect and ack in the same cycle with one read outstanding.
      lat = 1000;
      issue_n(1, "t4_reqs");
      d0 = dec_cnt;
      force_ack = 1'b1;
      redirect_to(32'h0000_2000, 32'h0000_2000);
      force_ack = 1'b0; lat = 1; HALT = 1'b0;
      repeat (4) @(negedge CLK);
      drain("t4");
      chk("t4_new_path_decoded", 32'(dec_cnt > d0), 32'd1);

      // HALT with two slow reads outstanding: responses still land, no new issue.
      DEC_READY = 1'b0; lat = 5;
      issue_n(2, "t5_reqs");
      s = req_cnt;
      repeat (8) @(negedge CLK);
      #4;
      chk("t5_no_issue_halted", 32'(req_cnt - s), 32'd0);
      chk("t5_level", 32'(IF_LEVEL), 32'd2);
      @(negedge CLK);
      lat = 1; DEC_READY = 1'b1; HALT = 1'b0;
      repeat (5) @(negedge CLK);
      drain("t5");

      // Spurious ack sets the sticky error; then fetch across the 32-bit wrap.
      DEC_READY = 1'b0; lat = 1;
      issue_n(1, "t6_reqs");
      repeat (3) @(negedge CLK);
      #4;
      chk("t6_level_pre", 32'(IF_LEVEL), 32'd1);
      chk("t6_proterr_pre", 32'(IF_PROTERR), 32'd0);
      @(negedge CLK); force_ack = 1'b1;
      @(negedge CLK); force_ack = 1'b0;
      #4;
      chk("t6_proterr_set", 32'(IF_PROTERR), 32'd1);
      chk("t6_level_unchanged", 32'(IF_LEVEL), 32'd1);
      repeat (5) @(negedge CLK);
      #4; chk("t6_proterr_sticky", 32'(IF_PROTERR), 32'd1);
      @(negedge CLK);
      saw_zero = 1'b0; DEC_READY = 1'b1;
      redirect_to(32'hFFFF_FFFA, 32'hFFFF_FFF8);
      HALT = 1'b0;
      repeat (6) @(negedge CLK);
      drain("t6");
      chk("t6_wrap_to_zero", 32'(saw_zero), 32'd1);
      chk("t6_proterr_end", 32'(IF_PROTERR), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lmi_ifetch_queue.md
Name: lmi_ifetch_queue

Overview:
- Instruction-fetch front end that sits directly downstream of the instruction-RAM bus wrapper.
- Generates the request side of that wrapper (NEXTADDR, RDOP_N, IS_VAL) and consumes its response side (IW_ACK, IW_DATAUPO, IW_MISS_R).
- Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles pipeline redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
DEPTH, 4, FIFO entries (power of 2, 2..16)
MAX_OUT, 2, maximum outstanding read requests (1..3)
RESET_VECTOR, 32'h8000_0000, fetch PC after reset (word aligned)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_D1_R_N  input  1  asynchronous active-low reset
REDIRECT  input  1  one-cycle pulse: restart fetch at REDIRECT_ADDR
REDIRECT_ADDR  input  32  new fetch PC; bits [1:0] ignored
HALT  input  1  suppresses new request issue; FIFO and responses unaffected
NEXTADDR  output  32  request address, valid when RDOP_N low
RDOP_N  output  1  active-low read strobe, one cycle per request
IS_VAL  output  1  request valid, equals ~RDOP_N
IW_ACK  input  1  one-cycle response strobe; responses return in request order
IW_DATAUPO  input  32  instruction word, valid with IW_ACK
IW_MISS_R  input  1  response pending on a miss; status only, not used for control
IF_INSTR  output  32  head-of-FIFO instruction
IF_PC  output  32  PC of IF_INSTR
IF_VALID  output  1  FIFO non-empty
DEC_READY  input  1  decode accepts the head entry when IF_VALID && DEC_READY
IF_LEVEL  output  5  current FIFO occupancy
IF_PROTERR  output  1  sticky: IW_ACK seen with no outstanding request

Behaviour:
- Reset (async, RESET_D1_R_N low):
  - RDOP_N=1, IS_VAL=0, NEXTADDR=RESET_VECTOR.
  - IF_VALID=0, IF_LEVEL=0, IF_INSTR=0, IF_PC=0, IF_PROTERR=0.
  - fetch_pc=resp_pc=RESET_VECTOR; outstanding=0, discard=0.
- Issue, combinational from registered state:
  - issue = ~HALT & ~REDIRECT & (outstanding < MAX_OUT) & (IF_LEVEL + outstanding < DEPTH).
  - When issue: RDOP_N=0, NEXTADDR=fetch_pc, then fetch_pc += 4 (mod 2^32, wrap allowed).
  - NEXTADDR=fetch_pc at all times.
- Credit rule: a request is issued only if a FIFO slot is reserved for it, so the FIFO never overflows. No backpressure exists on IW_ACK.
- Outstanding counter: next = outstanding + issue − IW_ACK. Discarded acks also decrement it.
- Response accept:
  - Condition: IW_ACK & (discard==0) & ~REDIRECT.
  - Writes {IW_DATAUPO, resp_pc} to the FIFO tail; resp_pc += 4.
- Redirect (REDIRECT=1), taking effect at the next edge:
  - FIFO flushed (IF_LEVEL=0, IF_VALID=0); a simultaneous decode pop is ignored.
  - fetch_pc = resp_pc = {REDIRECT_ADDR[31:2], 2'b00}.
  - discard = outstanding − IW_ACK in the same cycle. An ack in the redirect cycle is dropped.
  - No issue in the redirect cycle; issue may resume the following cycle.
- Discard: while discard>0, each IW_ACK decrements discard and its data is dropped.
  - A second redirect while discarding reloads discard from the current outstanding count.
- FIFO:
  - Pop on IF_VALID & DEC_READY; IF_INSTR/IF_PC show the head entry, registered or array-read with no extra cycle.
  - Simultaneous push and pop: level unchanged.
  - Push into an empty FIFO: IF_VALID=1 the next cycle (1-cycle ack-to-decode latency).
  - Pointers wrap modulo DEPTH.
- HALT: only blocks issue. Outstanding responses still fill the FIFO; decode can drain.
- IF_PROTERR: set when IW_ACK=1 and outstanding==0. The ack is ignored and the counter does not underflow. Cleared only by reset.

Test Plan:
- Reset release, ack 1 cycle after each request, DEC_READY=1 -> NEXTADDR issues 8000_0000, 8000_0004, ...; IF_PC follows the same sequence; IF_INSTR matches the acked data; at most 2 outstanding.
- DEC_READY=0, acks immediate -> exactly 4 requests issued, IF_LEVEL=4, RDOP_N stays 1; one pop -> one new request the next cycle.
- 2 outstanding, REDIRECT to 0000_1003 -> FIFO empties; the next 2 acks are dropped; the next request is 0000_1000; the first accepted IF_PC is 0000_1000.
- REDIRECT and IW_ACK in the same cycle with outstanding=1 -> that ack is dropped, discard=0, and the next ack after the new request is accepted with IF_PC = redirect target.
- HALT=1 with 2 outstanding and misses (acks delayed 5 cycles) -> no new RDOP_N; both words enter the FIFO; HALT=0 resumes at the correct fetch_pc.
- IW_ACK with no request pending -> IF_PROTERR=1 and sticky; IF_LEVEL unchanged; fetch_pc FFFF_FFFC wraps to 0000_0000.
